// File: rtl/div_seq_param.sv
// div_seq_param: parametrised multi-cycle restoring divider (DIV/REM unit beside the ALU).
// WIDTH-bit signed/unsigned division with valid/ready handshakes on both sides,
// plus divide-by-zero and signed-overflow flags.
// Optional feature: define DIV_ABORT_EN to add an 'abort' input that cancels a
// job in progress.
module div_seq_param #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
`ifdef DIV_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int              CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [1:0]       state_next;

    // Working registers: 'work' starts as |dividend| and shifts quotient bits in
    // from the right; part_rem is the restoring partial remainder.
    logic [WIDTH-1:0] work;
    logic [WIDTH:0]   part_rem;
    logic [WIDTH-1:0] divs;
    logic [CW-1:0]    count;
    logic             sign_q;
    logic             sign_r;
    logic             dbz_pend;
    logic             ovf_pend;

    logic             abort_req;
    logic             accept;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic             divisor_zero;
    logic             is_ovf;
    logic [WIDTH+1:0] diff;
    logic             step_ok;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + ONE;
    endfunction

`ifdef DIV_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    // Operand conditioning at accept: magnitudes, result signs and special cases
    always_comb begin
        dvd_neg      = signed_mode && dividend[WIDTH-1];
        dvs_neg      = signed_mode && divisor[WIDTH-1];
        dvd_abs      = dvd_neg ? negate(dividend) : dividend;
        dvs_abs      = dvs_neg ? negate(divisor) : divisor;
        divisor_zero = (divisor == '0);
        is_ovf       = signed_mode && (dividend == MIN_VAL) && (divisor == '1);
    end

    // One restoring step: shift in the next dividend bit and trial-subtract;
    // the extra top bit of diff is the borrow that decides whether to restore
    always_comb begin
        diff    = {part_rem, work[WIDTH-1]} - {2'b00, divs};
        step_ok = !diff[WIDTH+1];
    end

    // Next-state logic; abort only has an effect while a job is in flight
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = divisor_zero ? FIX : CALC;
                end
            end
            CALC: begin
                if (abort_req) begin
                    state_next = IDLE;
                end else if (count == LAST) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = abort_req ? IDLE : DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: latch conditioned operands at accept, then iterate MSB first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work     <= '0;
            part_rem <= '0;
            divs     <= '0;
            count    <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dbz_pend <= 1'b0;
            ovf_pend <= 1'b0;
        end else begin
            if (accept) begin
                work     <= divisor_zero ? dividend : dvd_abs;
                part_rem <= '0;
                divs     <= dvs_abs;
                count    <= '0;
                sign_q   <= dvd_neg ^ dvs_neg;
                sign_r   <= dvd_neg;
                dbz_pend <= divisor_zero;
                ovf_pend <= is_ovf;
            end else if (state == CALC) begin
                part_rem <= step_ok ? diff[WIDTH:0] : {part_rem[WIDTH-1:0], work[WIDTH-1]};
                work     <= {work[WIDTH-2:0], step_ok};
                count    <= (count == LAST) ? '0 : count + CW'(1);
            end
        end
    end

    // Result registers: sign fix-up in FIX, held in DONE, flags cleared on accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (accept) begin
                div_by_zero <= 1'b0;
                overflow    <= 1'b0;
            end else if (state == FIX && !abort_req) begin
                out_valid <= 1'b1;
                if (dbz_pend) begin
                    quotient    <= '1;
                    remainder   <= work;
                    div_by_zero <= 1'b1;
                    overflow    <= 1'b0;
                end else begin
                    quotient    <= sign_q ? negate(work) : work;
                    remainder   <= sign_r ? negate(part_rem[WIDTH-1:0]) : part_rem[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                    overflow    <= ovf_pend;
                end
            end else if (state == DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_seq_param.sv
// tb_div_seq_param: bench for div_seq_param (WIDTH=16). A queue-based arithmetic
// model predicts every result; directed jobs pin the model with literal values.
// Build with DIV_ABORT_EN defined to also exercise the abort input.
module tb_div_seq_param;

    localparam int W = 16;
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic         signed_mode;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;
`ifdef DIV_ABORT_EN
    logic         abort;
`endif

    int     compared   = 0;
    int     mismatched = 0;
    longint cycle      = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int           lat;
        longint       acc;
    } exp_t;

    exp_t expq[$];
    exp_t cmpEntry;
    exp_t popped;
    bit   seenFirst = 1'b0;

    div_seq_param #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
`ifdef DIV_ABORT_EN
        ,
        .abort       (abort)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Arithmetic reference: plain integer division with C-style truncation
    function automatic exp_t model(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic signed [W-1:0] ta;
        logic signed [W-1:0] tb;
        longint sa, sb, qq, rr;
        e.dz = 1'b0;
        e.ov = 1'b0;
        e.acc = 0;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.dz = 1'b1;
            e.lat = 1;
        end else begin
            e.lat = W + 1;
            if (sm) begin
                ta = a;
                tb = b;
                sa = ta;
                sb = tb;
            end else begin
                sa = a;
                sb = b;
            end
            if (sm && a == MINV && b == '1) begin
                e.q = MINV;
                e.r = '0;
                e.ov = 1'b1;
            end else begin
                qq = sa / sb;
                rr = sa % sb;
                e.q = qq[W-1:0];
                e.r = rr[W-1:0];
            end
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard: predict at accept, check every cycle a result is presented
    always @(negedge clk) begin
        if (reset) begin
            expq.delete();
            seenFirst = 1'b0;
        end else begin
`ifdef DIV_ABORT_EN
            if (abort && !in_ready && !out_valid && expq.size() > 0) begin
                popped = expq.pop_front();
            end
`endif
            if (out_valid) begin
                if (expq.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL spurious out_valid: got 1, expected 0");
                end else begin
                    cmpEntry = expq[0];
                    checkOutput("model quotient", quotient, cmpEntry.q);
                    checkOutput("model remainder", remainder, cmpEntry.r);
                    checkOutput("model div_by_zero", div_by_zero, cmpEntry.dz);
                    checkOutput("model overflow", overflow, cmpEntry.ov);
                    checkOutput("in_ready while done", in_ready, 0);
                    if (!seenFirst) begin
                        checkOutput("model latency", cycle - cmpEntry.acc, cmpEntry.lat);
                        seenFirst = 1'b1;
                    end
                    if (out_ready) begin
                        popped = expq.pop_front();
                        seenFirst = 1'b0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                cmpEntry = model(signed_mode, dividend, divisor);
                cmpEntry.acc = cycle + 1;
                expq.push_back(cmpEntry);
            end
        end
    end

    // Issue one job, wait (bounded) for the result, optionally stall the consumer
    task automatic applyStimulus(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int stall,
                                 output logic [W-1:0] q, output logic [W-1:0] r,
                                 output logic dz, output logic ov, output int lat);
        signed_mode = sm;
        dividend    = a;
        divisor     = b;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        dividend    = W'($urandom());
        divisor     = W'($urandom());
        signed_mode = 1'($urandom_range(0, 1));
        lat = 0;
        while (!out_valid && lat < W + 10) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL result timeout: got no out_valid, expected one within %0d cycles", W + 10);
        end
        q  = quotient;
        r  = remainder;
        dz = div_by_zero;
        ov = overflow;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        if (stall > 0) begin
            checkOutput("stall hold quotient", quotient, q);
            checkOutput("stall hold out_valid", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Directed job with hand-computed expectations
    task automatic runDirected(input string name, input bit sm, input logic [W-1:0] a,
                               input logic [W-1:0] b, input int stall,
                               input logic [W-1:0] eq, input logic [W-1:0] er,
                               input logic edz, input logic eov, input int elat);
        logic [W-1:0] q, r;
        logic dz, ov;
        int lat;
        applyStimulus(sm, a, b, stall, q, r, dz, ov, lat);
        checkOutput({name, " quotient"}, q, eq);
        checkOutput({name, " remainder"}, r, er);
        checkOutput({name, " div_by_zero"}, dz, edz);
        checkOutput({name, " overflow"}, ov, eov);
        checkOutput({name, " latency"}, lat, elat);
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [W-1:0] q, r;
        logic dz, ov;
        int lat;
        int seen;
        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        signed_mode = 1'b0;
        dividend    = '0;
        divisor     = '0;
`ifdef DIV_ABORT_EN
        abort       = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset quotient", quotient, 0);
        checkOutput("reset remainder", remainder, 0);
        checkOutput("reset flags", {div_by_zero, overflow}, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("in_ready after reset", in_ready, 1);

        runDirected("u 100/7",      1'b0, 16'd100,  16'd7,    0, 16'd14,   16'd2,    1'b0, 1'b0, 17);
        runDirected("s -100/7",     1'b1, 16'hFF9C, 16'd7,    0, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 17);
        runDirected("s 100/-7",     1'b1, 16'd100,  16'hFFF9, 0, 16'hFFF2, 16'd2,    1'b0, 1'b0, 17);
        runDirected("s min/-1",     1'b1, 16'h8000, 16'hFFFF, 0, 16'h8000, 16'd0,    1'b0, 1'b1, 17);
        runDirected("u 8000/FFFF",  1'b0, 16'h8000, 16'hFFFF, 0, 16'd0,    16'h8000, 1'b0, 1'b0, 17);
        runDirected("u FFFF/2",     1'b0, 16'hFFFF, 16'd2,    0, 16'h7FFF, 16'd1,    1'b0, 1'b0, 17);
        runDirected("u 5/0",        1'b0, 16'd5,    16'd0,    0, 16'hFFFF, 16'd5,    1'b1, 1'b0, 1);
        runDirected("after dbz",    1'b0, 16'd100,  16'd7,    0, 16'd14,   16'd2,    1'b0, 1'b0, 17);
        runDirected("s -5/0",       1'b1, 16'hFFFB, 16'd0,    0, 16'hFFFF, 16'hFFFB, 1'b1, 1'b0, 1);
        runDirected("stall 1000/10",1'b0, 16'd1000, 16'd10,   5, 16'd100,  16'd0,    1'b0, 1'b0, 17);

        // Reset in the middle of CALC discards the job and clears outputs
        signed_mode = 1'b0;
        dividend    = 16'd50;
        divisor     = 16'd3;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("mid reset out_valid", out_valid, 0);
        checkOutput("mid reset quotient", quotient, 0);
        checkOutput("mid reset remainder", remainder, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        runDirected("after reset 77/7", 1'b0, 16'd77, 16'd7, 0, 16'd11, 16'd0, 1'b0, 1'b0, 17);

`ifdef DIV_ABORT_EN
        // Abort during CALC: no result, back to IDLE, next job unaffected
        signed_mode = 1'b0;
        dividend    = 16'd500;
        divisor     = 16'd9;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        seen = 0;
        repeat (W + 4) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        checkOutput("abort no out_valid", seen, 0);
        checkOutput("abort in_ready", in_ready, 1);
        runDirected("after abort 9/3", 1'b0, 16'd9, 16'd3, 0, 16'd3, 16'd0, 1'b0, 1'b0, 17);
`endif

        // Random jobs checked by the scoreboard only
        for (int k = 0; k < 40; k++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom());
            rb = (k % 4 == 0) ? W'($urandom_range(0, 15)) : W'($urandom());
            if (k % 10 == 3) rb = '0;
            applyStimulus(1'($urandom_range(0, 1)), ra, rb, k % 3, q, r, dz, ov, lat);
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
